// File: rtl/nes_button_events.sv
// Debounces the eight NES button levels, emits press/release pulses, auto-repeats the
// direction buttons and queues every event in a small FWFT FIFO. The release pulse port is `released` because `release` is a reserved word.
module nes_button_events #(
  parameter int unsigned DEBOUNCE_SAMPLES = 3,
  parameter int unsigned REPEAT_DELAY     = 24,
  parameter int unsigned REPEAT_RATE      = 6,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       frame_tick,
  input  logic [7:0] btn_in,
  output logic [7:0] held,
  output logic [7:0] press,
  output logic [7:0] released,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic       evt_overflow
);

  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam bit          REP_EN = (REPEAT_RATE != 0);

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  logic [3:0]    cnt [8];
  logic [7:0]    rc [4:7];
  logic [7:0]    rep_fire;
  logic [7:0]    pend_p, pend_r, pend_x;
  logic [7:0]    clr_p, clr_r, clr_x;
  logic          found, push, pop, can_accept, merge;
  logic [2:0]    sel_idx;
  evt_type_t     sel_type;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Debounce and edge pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held     <= '0;
      press    <= '0;
      released <= '0;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      press    <= '0;
      released <= '0;
      if (sample_tick) begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (btn_in[i] != held[i]) begin
            if (cnt[i] == 4'(DEBOUNCE_SAMPLES - 1)) begin
              held[i]     <= btn_in[i];
              cnt[i]      <= '0;
              press[i]    <= btn_in[i];
              released[i] <= ~btn_in[i];
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Repeat fires when the countdown expires on a frame tick; the press cycle itself only reloads.
  always_comb begin
    rep_fire = '0;
    for (int unsigned i = 4; i < 8; i++)
      rep_fire[i] = REP_EN && frame_tick && held[i] && !press[i] && (rc[i] == 8'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 4; i < 8; i++) rc[i] <= '0;
    end else begin
      for (int unsigned i = 4; i < 8; i++) begin
        if (press[i])
          rc[i] <= 8'(REPEAT_DELAY);
        else if (released[i])
          rc[i] <= '0;
        else if (REP_EN && frame_tick && held[i]) begin
          if (rc[i] == 8'd1)
            rc[i] <= 8'(REPEAT_RATE);
          else if (rc[i] != 8'd0)
            rc[i] <= rc[i] - 8'd1;
        end
      end
    end
  end

  // Arbiter: lowest button first, then release, press, repeat within a button
  assign pop        = evt_valid & evt_ready;
  assign can_accept = (count < CW'(FIFO_DEPTH)) || pop;

  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_type = EVT_NONE;
    clr_p    = '0;
    clr_r    = '0;
    clr_x    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found) begin
        if (pend_r[i]) begin
          found = 1'b1; sel_idx = 3'(i); sel_type = EVT_RELEASE;
        end else if (pend_p[i]) begin
          found = 1'b1; sel_idx = 3'(i); sel_type = EVT_PRESS;
        end else if (pend_x[i]) begin
          found = 1'b1; sel_idx = 3'(i); sel_type = EVT_REPEAT;
        end
      end
    end
    push = found && can_accept;
    if (push) begin
      case (sel_type)
        EVT_RELEASE: clr_r[sel_idx] = 1'b1;
        EVT_PRESS:   clr_p[sel_idx] = 1'b1;
        EVT_REPEAT:  clr_x[sel_idx] = 1'b1;
        default:     ;
      endcase
    end
  end

  // A flag consumed in the same cycle it is re-raised is not a merge.
  assign merge = |((released & pend_r & ~clr_r) |
                   (press    & pend_p & ~clr_p) |
                   (rep_fire & pend_x & ~clr_x));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_p       <= '0;
      pend_r       <= '0;
      pend_x       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend_p <= (pend_p & ~clr_p) | press;
      pend_r <= (pend_r & ~clr_r) | released;
      pend_x <= (pend_x & ~clr_x) | rep_fire;
      if (merge) evt_overflow <= 1'b1;
    end
  end

  // Event FIFO, first-word-fall-through
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel_type, sel_idx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt_valid = (count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_nes_button_events.sv
// Directed bench for nes_button_events with an event scoreboard drained by a negedge monitor.
module tb_nes_button_events;

  logic       clk = 1'b0;
  logic       reset, sample_tick, frame_tick, evt_ready;
  logic [7:0] btn_in;
  logic [7:0] held, press, released;
  logic       evt_valid, evt_overflow;
  logic [4:0] evt_data;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned press_seen = 0;
  logic [4:0]  exp_q [$];

  nes_button_events #(
    .DEBOUNCE_SAMPLES(3),
    .REPEAT_DELAY(24),
    .REPEAT_RATE(6),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .frame_tick(frame_tick),
    .btn_in(btn_in),
    .held(held),
    .press(press),
    .released(released),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every accepted FIFO entry is compared against the oldest expected event
  always @(negedge clk) begin
    if (press != 8'h00) press_seen++;
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0)
        check("evt_unexpected_pending_expected", 32'(exp_q.size()), 32'd1);
      else
        check("evt_data", {27'd0, evt_data}, {27'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick(input logic [7:0] b);
    step();
    btn_in      = b;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic tick3(input logic [7:0] b);
    for (int k = 0; k < 3; k++) tick(b);
  endtask

  task automatic frame();
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_low"}, {31'd0, evt_valid}, 32'd0);
  endtask

  initial begin
    int unsigned ps;
    int unsigned rc;
    reset       = 1'b1;
    sample_tick = 1'b0;
    frame_tick  = 1'b0;
    evt_ready   = 1'b0;
    btn_in      = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_held", held, 8'h00);
    check("rst_press", press, 8'h00);
    check("rst_release", released, 8'h00);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_data", evt_data, 5'd0);
    check("rst_overflow", evt_overflow, 1'b0);
    reset = 1'b0;

    // Power-up all-pressed glitch is filtered
    tick(8'hFF);
    for (int k = 0; k < 5; k++) tick(8'h00);
    step();
    check("glitch_held", held, 8'h00);
    check("glitch_press", press_seen, 0);
    check("glitch_valid", evt_valid, 1'b0);

    // Single press: debounce threshold and push latency
    tick(8'h01);
    tick(8'h01);
    check("a_held_after2", held, 8'h00);
    tick(8'h01);
    check("a_held_after3", held, 8'h01);
    check("a_press_pulse", press, 8'h01);
    check("a_valid_n", evt_valid, 1'b0);
    exp_q.push_back(5'b01_000);
    step();
    check("a_press_gone", press, 8'h00);
    check("a_valid_n1", evt_valid, 1'b0);
    step();
    check("a_valid_n2", evt_valid, 1'b1);
    check("a_data_head", evt_data, 5'b01_000);
    evt_ready = 1'b1;
    step();
    check("a_valid_after_pop", evt_valid, 1'b0);
    tick3(8'h00);
    check("a_release_pulse", released, 8'h01);
    check("a_held_released", held, 8'h00);
    exp_q.push_back(5'b10_000);
    wait_drain("a_drain", 50);

    // Bouncing input never settles
    ps = press_seen;
    for (int k = 0; k < 10; k++) tick((k % 2 == 0) ? 8'h10 : 8'h00);
    repeat (4) step();
    check("bounce_held", held, 8'h00);
    check("bounce_press", press_seen, ps);
    check("bounce_valid", evt_valid, 1'b0);

    // Auto-repeat on up: expected repeats come from a countdown model
    tick3(8'h10);
    check("up_held", held, 8'h10);
    exp_q.push_back(5'b01_100);
    rc = 24;
    for (int f = 1; f <= 60; f++) begin
      if (rc == 1) begin
        exp_q.push_back(5'b11_100);
        rc = 6;
      end else begin
        rc = rc - 1;
      end
      frame();
    end
    tick3(8'h00);
    exp_q.push_back(5'b10_100);
    wait_drain("repeat_drain", 200);

    // All buttons at once with a stalled consumer
    evt_ready = 1'b0;
    tick3(8'hFF);
    for (int i = 0; i < 8; i++) exp_q.push_back({2'b01, 3'(i)});
    repeat (10) step();
    check("all_valid", evt_valid, 1'b1);
    check("all_head", evt_data, 5'b01_000);
    check("all_overflow_stalled", evt_overflow, 1'b0);
    evt_ready = 1'b1;
    wait_drain("all_press_drain", 100);
    check("all_overflow", evt_overflow, 1'b0);
    tick3(8'h00);
    for (int i = 0; i < 8; i++) exp_q.push_back({2'b10, 3'(i)});
    wait_drain("all_release_drain", 100);

    // Merge while full sets sticky overflow
    evt_ready = 1'b0;
    tick3(8'h1E);
    for (int i = 1; i <= 4; i++) exp_q.push_back({2'b01, 3'(i)});
    repeat (6) step();
    tick3(8'h1F);
    tick3(8'h1E);
    check("merge_ovf_before", evt_overflow, 1'b0);
    tick3(8'h1F);
    step();
    check("merge_ovf_set", evt_overflow, 1'b1);
    exp_q.push_back(5'b10_000);
    exp_q.push_back(5'b01_000);
    evt_ready = 1'b1;
    wait_drain("merge_drain", 100);
    check("merge_ovf_sticky", evt_overflow, 1'b1);
    tick3(8'h00);
    for (int i = 0; i <= 4; i++) exp_q.push_back({2'b10, 3'(i)});
    wait_drain("merge_release_drain", 100);
    check("merge_ovf_still", evt_overflow, 1'b1);

    // Asynchronous reset with entries queued
    evt_ready = 1'b0;
    tick3(8'h07);
    repeat (6) step();
    check("pre_rst_valid", evt_valid, 1'b1);
    check("pre_rst_held", held, 8'h07);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", evt_valid, 1'b0);
    check("arst_held", held, 8'h00);
    check("arst_overflow", evt_overflow, 1'b0);
    check("arst_data", evt_data, 5'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    btn_in = 8'h00;
    repeat (4) step();
    check("post_rst_valid", evt_valid, 1'b0);
    check("post_rst_held", held, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
